// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream mux with a registered output stage, select or round-robin grant.
// Define STREAM_MUX_PACKET_LOCK_EN to hold the grant on one channel until its in_last beat.
module stream_mux_rr #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          select,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_last,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);
  logic [WIDTH-1:0] out_data_q, out_data_d, data_g;
  logic             out_last_q, out_last_d, out_valid_q, out_valid_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d, rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0] g, rr_g, c;
  logic             gnt_vld, rr_hit, load, in_xfer, last_g;
`ifdef STREAM_MUX_PACKET_LOCK_EN
  typedef enum logic {UNLOCKED, LOCKED} lock_t;
  lock_t            lock_q, lock_d;
  logic [SEL_W-1:0] lock_chan_q, lock_chan_d;
`endif
  // Walk channels starting just after the last grant, wrapping at CHANNELS.
  always_comb begin
    rr_hit = 1'b0;
    rr_g = '0;
    c = rr_ptr_q;
    for (int i = 0; i < CHANNELS; i++) begin
      c = (c == SEL_W'(CHANNELS - 1)) ? '0 : c + 1'b1;
      if (!rr_hit && in_valid[c]) begin
        rr_hit = 1'b1;
        rr_g = c;
      end
    end
  end
  always_comb begin
    g = mode ? rr_g : select;
    gnt_vld = mode ? rr_hit : (int'(select) < CHANNELS);
`ifdef STREAM_MUX_PACKET_LOCK_EN
    if (lock_q == LOCKED) begin
      g = lock_chan_q;
      gnt_vld = 1'b1;
    end
`endif
    load = !out_valid_q || out_ready;
    in_ready = '0;
    data_g = '0;
    last_g = 1'b0;
    for (int i = 0; i < CHANNELS; i++)
      if (g == SEL_W'(i)) begin
        in_ready[i] = gnt_vld && load && rst_n;
        data_g = data_in[i*WIDTH +: WIDTH];
        last_g = in_last[i];
      end
    in_xfer = |(in_ready & in_valid);
    out_valid_d = load ? in_xfer : out_valid_q;
    out_data_d = in_xfer ? data_g : out_data_q;
    out_last_d = in_xfer ? last_g : out_last_q;
    out_chan_d = in_xfer ? g : out_chan_q;
`ifdef STREAM_MUX_PACKET_LOCK_EN
    lock_d = in_xfer ? (last_g ? UNLOCKED : LOCKED) : lock_q;
    lock_chan_d = in_xfer ? g : lock_chan_q;
    rr_ptr_d = (in_xfer && last_g) ? g : rr_ptr_q;
`else
    rr_ptr_d = in_xfer ? g : rr_ptr_q;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_chan_q <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q <= SEL_W'(CHANNELS - 1);
`ifdef STREAM_MUX_PACKET_LOCK_EN
      lock_q <= UNLOCKED;
      lock_chan_q <= '0;
`endif
    end else begin
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      out_chan_q <= out_chan_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef STREAM_MUX_PACKET_LOCK_EN
      lock_q <= lock_d;
      lock_chan_q <= lock_chan_d;
`endif
    end
  end
  assign out_data = out_data_q;
  assign out_last = out_last_q;
  assign out_chan = out_chan_q;
  assign out_valid = out_valid_q;
endmodule
